// File: rtl/tl_bank_buffer_pkg.sv
// ============================================================================
// tl_bank_pkg : TileLink-UL field widths, opcodes and A/D beat structs
// Rev 1.0
// ============================================================================
`default_nettype none

package tl_bank_pkg;

  localparam int TL_OPCODE_W = 3;
  localparam int TL_SIZE_W   = 3;
  localparam int TL_SOURCE_W = 7;
  localparam int TL_ADDR_W   = 32;
  localparam int TL_DATA_W   = 64;
  localparam int TL_MASK_W   = 8;
  localparam int TL_PROT_W   = 7;

  localparam logic [TL_OPCODE_W-1:0] TL_A_PUT_FULL_DATA    = 3'd0;
  localparam logic [TL_OPCODE_W-1:0] TL_A_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [TL_OPCODE_W-1:0] TL_A_ARITHMETIC_DATA  = 3'd2;
  localparam logic [TL_OPCODE_W-1:0] TL_A_LOGICAL_DATA     = 3'd3;
  localparam logic [TL_OPCODE_W-1:0] TL_A_GET              = 3'd4;
  localparam logic [TL_OPCODE_W-1:0] TL_A_INTENT           = 3'd5;
  localparam logic [TL_OPCODE_W-1:0] TL_D_ACCESS_ACK       = 3'd0;
  localparam logic [TL_OPCODE_W-1:0] TL_D_ACCESS_ACK_DATA  = 3'd1;
  localparam logic [TL_OPCODE_W-1:0] TL_D_HINT_ACK         = 3'd2;

  // Bit positions of the AMBA prot user bits inside tl_a_t.prot
  localparam int TL_PROT_BUFFERABLE = 0;
  localparam int TL_PROT_MODIFIABLE = 1;
  localparam int TL_PROT_READALLOC  = 2;
  localparam int TL_PROT_WRITEALLOC = 3;
  localparam int TL_PROT_PRIVILEGED = 4;
  localparam int TL_PROT_SECURE     = 5;
  localparam int TL_PROT_FETCH      = 6;

  typedef struct packed {
    logic [TL_OPCODE_W-1:0] opcode;
    logic [TL_SIZE_W-1:0]   size;
    logic [TL_SOURCE_W-1:0] source;
    logic [TL_ADDR_W-1:0]   address;
    logic [TL_PROT_W-1:0]   prot;
    logic [TL_MASK_W-1:0]   mask;
    logic [TL_DATA_W-1:0]   data;
  } tl_a_t;

  typedef struct packed {
    logic [TL_OPCODE_W-1:0] opcode;
    logic [TL_SIZE_W-1:0]   size;
    logic [TL_SOURCE_W-1:0] source;
    logic                   denied;
    logic [TL_DATA_W-1:0]   data;
    logic                   corrupt;
  } tl_d_t;

endpackage

`default_nettype wire

// File: rtl/tl_bank_buffer_if.sv
// ============================================================================
// tl_bank_buffer_if : one TileLink-UL link (A request + D response channel)
// Rev 1.0
// ============================================================================
`default_nettype none

interface tl_bank_buffer_if;
  import tl_bank_pkg::*;

  logic                   a_ready;
  logic                   a_valid;
  logic [TL_OPCODE_W-1:0] a_bits_opcode;
  logic [TL_SIZE_W-1:0]   a_bits_size;
  logic [TL_SOURCE_W-1:0] a_bits_source;
  logic [TL_ADDR_W-1:0]   a_bits_address;
  logic                   a_bits_user_amba_prot_bufferable;
  logic                   a_bits_user_amba_prot_modifiable;
  logic                   a_bits_user_amba_prot_readalloc;
  logic                   a_bits_user_amba_prot_writealloc;
  logic                   a_bits_user_amba_prot_privileged;
  logic                   a_bits_user_amba_prot_secure;
  logic                   a_bits_user_amba_prot_fetch;
  logic [TL_MASK_W-1:0]   a_bits_mask;
  logic [TL_DATA_W-1:0]   a_bits_data;

  logic                   d_ready;
  logic                   d_valid;
  logic [TL_OPCODE_W-1:0] d_bits_opcode;
  logic [TL_SIZE_W-1:0]   d_bits_size;
  logic [TL_SOURCE_W-1:0] d_bits_source;
  logic                   d_bits_denied;
  logic                   d_bits_corrupt;
  logic [TL_DATA_W-1:0]   d_bits_data;

  // Master issues requests on A and consumes responses on D
  modport master (
    input  a_ready,
    output a_valid, a_bits_opcode, a_bits_size, a_bits_source, a_bits_address,
           a_bits_user_amba_prot_bufferable, a_bits_user_amba_prot_modifiable,
           a_bits_user_amba_prot_readalloc, a_bits_user_amba_prot_writealloc,
           a_bits_user_amba_prot_privileged, a_bits_user_amba_prot_secure,
           a_bits_user_amba_prot_fetch, a_bits_mask, a_bits_data,
    output d_ready,
    input  d_valid, d_bits_opcode, d_bits_size, d_bits_source, d_bits_denied,
           d_bits_corrupt, d_bits_data
  );

  modport slave (
    output a_ready,
    input  a_valid, a_bits_opcode, a_bits_size, a_bits_source, a_bits_address,
           a_bits_user_amba_prot_bufferable, a_bits_user_amba_prot_modifiable,
           a_bits_user_amba_prot_readalloc, a_bits_user_amba_prot_writealloc,
           a_bits_user_amba_prot_privileged, a_bits_user_amba_prot_secure,
           a_bits_user_amba_prot_fetch, a_bits_mask, a_bits_data,
    input  d_ready,
    output d_valid, d_bits_opcode, d_bits_size, d_bits_source, d_bits_denied,
           d_bits_corrupt, d_bits_data
  );

endinterface

`default_nettype wire

// File: rtl/tl_bank_buffer_queue.sv
// ============================================================================
// tl_bank_queue : generic valid/ready FIFO; bypass enabled by TL_BANK_BUFFER_FLOW_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module tl_bank_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_bits,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_bits
);

  localparam int              PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CNT_W      = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             init_done;
  logic             full;
  logic             empty;
  logic             do_enq;
  logic             do_deq;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  // Ready is purely registered so no ready->ready path crosses the buffer
  assign enq_ready = init_done & ~full;

`ifdef TL_BANK_BUFFER_FLOW_EN
  logic flow;

  assign flow      = empty & enq_valid & init_done;
  assign deq_valid = ~empty | flow;
  assign deq_bits  = flow ? enq_bits : storage[rd_ptr];
  assign do_enq    = enq_valid & enq_ready & ~(flow & deq_ready);
  assign do_deq    = ~empty & deq_ready;
`else
  assign deq_valid = ~empty;
  assign deq_bits  = storage[rd_ptr];
  assign do_enq    = enq_valid & enq_ready;
  assign do_deq    = deq_valid & deq_ready;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      init_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else begin
      init_done <= 1'b1;
      if (do_enq) begin
        storage[wr_ptr] <= enq_bits;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (do_deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_enq) - CNT_W'(do_deq);
    end
  end

endmodule

`default_nettype wire

// File: rtl/tl_bank_buffer.sv
// ============================================================================
// tl_bank_buffer : registered TL-UL A/D buffer toward one bank; option TL_BANK_BUFFER_FLOW_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module tl_bank_buffer
  import tl_bank_pkg::*;
#(
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  tl_bank_buffer_if.slave    auto_in,
  tl_bank_buffer_if.master   auto_out
);

  tl_a_t a_enq_bits;
  tl_a_t a_deq_bits;
  tl_d_t d_enq_bits;
  tl_d_t d_deq_bits;

  always_comb begin
    a_enq_bits                          = '0;
    a_enq_bits.opcode                   = auto_in.a_bits_opcode;
    a_enq_bits.size                     = auto_in.a_bits_size;
    a_enq_bits.source                   = auto_in.a_bits_source;
    a_enq_bits.address                  = auto_in.a_bits_address;
    a_enq_bits.prot[TL_PROT_BUFFERABLE] = auto_in.a_bits_user_amba_prot_bufferable;
    a_enq_bits.prot[TL_PROT_MODIFIABLE] = auto_in.a_bits_user_amba_prot_modifiable;
    a_enq_bits.prot[TL_PROT_READALLOC]  = auto_in.a_bits_user_amba_prot_readalloc;
    a_enq_bits.prot[TL_PROT_WRITEALLOC] = auto_in.a_bits_user_amba_prot_writealloc;
    a_enq_bits.prot[TL_PROT_PRIVILEGED] = auto_in.a_bits_user_amba_prot_privileged;
    a_enq_bits.prot[TL_PROT_SECURE]     = auto_in.a_bits_user_amba_prot_secure;
    a_enq_bits.prot[TL_PROT_FETCH]      = auto_in.a_bits_user_amba_prot_fetch;
    a_enq_bits.mask                     = auto_in.a_bits_mask;
    a_enq_bits.data                     = auto_in.a_bits_data;
  end

  always_comb begin
    d_enq_bits         = '0;
    d_enq_bits.opcode  = auto_out.d_bits_opcode;
    d_enq_bits.size    = auto_out.d_bits_size;
    d_enq_bits.source  = auto_out.d_bits_source;
    d_enq_bits.denied  = auto_out.d_bits_denied;
    d_enq_bits.data    = auto_out.d_bits_data;
    d_enq_bits.corrupt = auto_out.d_bits_corrupt;
  end

  tl_bank_queue #(
    .WIDTH ($bits(tl_a_t)),
    .DEPTH (A_DEPTH)
  ) u_a_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (auto_in.a_valid),
    .enq_ready (auto_in.a_ready),
    .enq_bits  (a_enq_bits),
    .deq_valid (auto_out.a_valid),
    .deq_ready (auto_out.a_ready),
    .deq_bits  (a_deq_bits)
  );

  tl_bank_queue #(
    .WIDTH ($bits(tl_d_t)),
    .DEPTH (D_DEPTH)
  ) u_d_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (auto_out.d_valid),
    .enq_ready (auto_out.d_ready),
    .enq_bits  (d_enq_bits),
    .deq_valid (auto_in.d_valid),
    .deq_ready (auto_in.d_ready),
    .deq_bits  (d_deq_bits)
  );

  assign auto_out.a_bits_opcode                    = a_deq_bits.opcode;
  assign auto_out.a_bits_size                      = a_deq_bits.size;
  assign auto_out.a_bits_source                    = a_deq_bits.source;
  assign auto_out.a_bits_address                   = a_deq_bits.address;
  assign auto_out.a_bits_user_amba_prot_bufferable = a_deq_bits.prot[TL_PROT_BUFFERABLE];
  assign auto_out.a_bits_user_amba_prot_modifiable = a_deq_bits.prot[TL_PROT_MODIFIABLE];
  assign auto_out.a_bits_user_amba_prot_readalloc  = a_deq_bits.prot[TL_PROT_READALLOC];
  assign auto_out.a_bits_user_amba_prot_writealloc = a_deq_bits.prot[TL_PROT_WRITEALLOC];
  assign auto_out.a_bits_user_amba_prot_privileged = a_deq_bits.prot[TL_PROT_PRIVILEGED];
  assign auto_out.a_bits_user_amba_prot_secure     = a_deq_bits.prot[TL_PROT_SECURE];
  assign auto_out.a_bits_user_amba_prot_fetch      = a_deq_bits.prot[TL_PROT_FETCH];
  assign auto_out.a_bits_mask                      = a_deq_bits.mask;
  assign auto_out.a_bits_data                      = a_deq_bits.data;

  assign auto_in.d_bits_opcode  = d_deq_bits.opcode;
  assign auto_in.d_bits_size    = d_deq_bits.size;
  assign auto_in.d_bits_source  = d_deq_bits.source;
  assign auto_in.d_bits_denied  = d_deq_bits.denied;
  assign auto_in.d_bits_data    = d_deq_bits.data;
  assign auto_in.d_bits_corrupt = d_deq_bits.corrupt;

endmodule

`default_nettype wire
